fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipeline. It owns the PC, issues instruction-memory reads, and absorbs the stall, flush and redirect controls from the hazard detection unit and the datapath. It also holds a one-entry skid buffer so an instruction returned during a stall is kept and not re-requested. Its IF/ID outputs feed decode, and its `pc_id` / `instr_id` fields are what the hazard unit compares against.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid
// buffer that keeps an instruction returned while the stage is stalled.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] iload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        pc_wen,
   input  logic        stall_ifid,
   input  logic        flush_ifid,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        dmem_busy,
   output logic [31:0] instr_id,
   output logic [31:0] pc_id,
   output logic [31:0] npc_id,
   output logic        valid_id,
   output logic        state_dbg_o
);

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] instr_id_q, instr_id_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic [31:0] npc_id_q, npc_id_d;
   logic        valid_id_q, valid_id_d;
   logic [31:0] pc_plus4;

   // Handshake: a fetch completes on any rising edge where iREN and ihit are
   // both high and the stage is not frozen; there is no separate accept.
   assign iREN        = nRST & (state_q == ST_FETCH);
   assign iaddr       = pc_q;
   assign instr_id    = instr_id_q;
   assign pc_id       = pc_id_q;
   assign npc_id      = npc_id_q;
   assign valid_id    = valid_id_q;
   assign state_dbg_o = state_q[0];

   // In HOLD the PC is held at buf_pc, so pc_q + 4 also serves the buffer.
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      instr_id_d  = instr_id_q;
      pc_id_d     = pc_id_q;
      npc_id_d    = npc_id_q;
      valid_id_d  = valid_id_q;

      if (dmem_busy) begin
         state_d = state_q;
      end else if (redirect_en) begin
         pc_d       = redirect_pc;
         instr_id_d = 32'h0;
         valid_id_d = 1'b0;
         state_d    = ST_FETCH;
      end else if (flush_ifid) begin
         instr_id_d = 32'h0;
         valid_id_d = 1'b0;
         state_d    = ST_FETCH;
      end else if (stall_ifid || !pc_wen) begin
         if (state_q == ST_FETCH && ihit) begin
            buf_instr_d = iload;
            buf_pc_d    = pc_q;
            state_d     = ST_HOLD;
         end
      end else if (state_q == ST_FETCH) begin
         if (ihit) begin
            instr_id_d = iload;
            pc_id_d    = pc_q;
            npc_id_d   = pc_plus4;
            valid_id_d = 1'b1;
            pc_d       = pc_plus4;
         end else begin
            instr_id_d = 32'h0;
            valid_id_d = 1'b0;
         end
      end else begin
         instr_id_d = buf_instr_q;
         pc_id_d    = buf_pc_q;
         npc_id_d   = pc_plus4;
         valid_id_d = 1'b1;
         pc_d       = pc_plus4;
         state_d    = ST_FETCH;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_FETCH;
         pc_q        <= PC_INIT;
         buf_instr_q <= 32'h0;
         buf_pc_q    <= 32'h0;
         instr_id_q  <= 32'h0;
         pc_id_q     <= 32'h0;
         npc_id_q    <= 32'h0;
         valid_id_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         instr_id_q  <= instr_id_d;
         pc_id_q     <= pc_id_d;
         npc_id_q    <= npc_id_d;
         valid_id_q  <= valid_id_d;
      end
   end

endmodule
